// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// The master side is the pipeline plus Data_Memory; the slave side is the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [2:0]  funct3;
  logic [63:0] Addr;
  logic [63:0] StoreData;
  logic        resp_valid;
  logic [63:0] Load_Result;
  logic        fault;
  logic [63:0] Mem_Addr;
  logic [63:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] Read_Data;

  modport master (
    output req_valid, MemRead_in, MemWrite_in, funct3, Addr, StoreData, Read_Data,
    input  req_ready, resp_valid, Load_Result, fault, Mem_Addr, WriteData, MemWrite, MemRead
  );

  modport slave (
    input  req_valid, MemRead_in, MemWrite_in, funct3, Addr, StoreData, Read_Data,
    output req_ready, resp_valid, Load_Result, fault, Mem_Addr, WriteData, MemWrite, MemRead
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: maps byte-addressed loads/stores onto doubleword memory accesses,
// using read-modify-write for sub-doubleword stores and faulting bad requests before any access.
module load_store_unit #(
  parameter int MEM_BYTES = 64
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic [63:0] base_q;
  logic [2:0]  lane_q;
  logic [2:0]  funct3_q;
  logic        is_load_q;
  logic [63:0] store_q;
  logic [63:0] merged_q;
  logic [63:0] load_q;
  logic        fault_q;

  logic        accept;
  logic        req_fault;
  logic        misalign;

  function automatic logic [63:0] extend_load(input logic [63:0] d, input logic [2:0] lane,
                                              input logic [2:0] f3);
    logic [63:0] s;
    s = d >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{56{s[7]}}, s[7:0]};
      3'b001:  return {{48{s[15]}}, s[15:0]};
      3'b010:  return {{32{s[31]}}, s[31:0]};
      3'b100:  return {56'd0, s[7:0]};
      3'b101:  return {48'd0, s[15:0]};
      3'b110:  return {32'd0, s[31:0]};
      default: return s;
    endcase
  endfunction

  // Replace bytes lane..lane+size-1 of the old doubleword with the low store bytes.
  function automatic logic [63:0] merge_store(input logic [63:0] d, input logic [63:0] st,
                                              input logic [2:0] lane, input logic [1:0] sz);
    logic [63:0] m;
    case (sz)
      2'b00:   m = 64'h0000_0000_0000_00FF;
      2'b01:   m = 64'h0000_0000_0000_FFFF;
      2'b10:   m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return (d & ~(m << {lane, 3'b000})) | ((st & m) << {lane, 3'b000});
  endfunction

  assign accept = bus.req_valid && (state_q == IDLE);

  always_comb begin
    misalign = 1'b0;
    case (bus.funct3[1:0])
      2'b01:   misalign = bus.Addr[0];
      2'b10:   misalign = (bus.Addr[1:0] != 2'b00);
      2'b11:   misalign = (bus.Addr[2:0] != 3'b000);
      default: misalign = 1'b0;
    endcase
    req_fault = (bus.MemRead_in == bus.MemWrite_in)
             || (bus.funct3 == 3'b111)
             || (bus.MemWrite_in && bus.funct3[2])
             || misalign
             || ({bus.Addr[63:3], 3'b111} >= 64'(MEM_BYTES));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      lane_q    <= '0;
      funct3_q  <= '0;
      is_load_q <= 1'b0;
      store_q   <= '0;
      merged_q  <= '0;
      load_q    <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q    <= {bus.Addr[63:3], 3'b000};
        lane_q    <= bus.Addr[2:0];
        funct3_q  <= bus.funct3;
        is_load_q <= bus.MemRead_in;
        store_q   <= bus.StoreData;
        merged_q  <= bus.StoreData;
        fault_q   <= req_fault;
        if (req_fault) load_q <= '0;
      end else if (state_q == RD) begin
        if (is_load_q) load_q <= extend_load(bus.Read_Data, lane_q, funct3_q);
        else           merged_q <= merge_store(bus.Read_Data, store_q, lane_q, funct3_q[1:0]);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.fault       = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.Mem_Addr    = '0;
    bus.WriteData   = '0;
    bus.Load_Result = load_q;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          if (req_fault)                                      state_d = RESP;
          else if (bus.MemRead_in || bus.funct3[1:0] != 2'b11) state_d = RD;
          else                                                state_d = WR;
        end
      end
      RD: begin
        bus.MemRead  = 1'b1;
        bus.Mem_Addr = base_q;
        state_d      = is_load_q ? RESP : WR;
      end
      WR: begin
        bus.MemWrite  = 1'b1;
        bus.Mem_Addr  = base_q;
        bus.WriteData = merged_q;
        state_d       = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.fault      = fault_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 64-byte data memory.
module tb_load_store_unit;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   cyc;
  int   rd_cnt;
  int   wr_cnt;
  int   both_cnt;

  logic [63:0] mem [0:7];

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.Read_Data = mem[bus.Mem_Addr[5:3]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.MemWrite) mem[bus.Mem_Addr[5:3]] <= bus.WriteData;
    if (bus.MemRead) rd_cnt <= rd_cnt + 1;
    if (bus.MemWrite) wr_cnt <= wr_cnt + 1;
    if (bus.MemRead && bus.MemWrite) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request when the unit is ready and waits (bounded) for its response.
  task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] d,
                     output int lat, output logic [63:0] res, output logic flt,
                     output int nrd, output int nwr);
    int r0, w0;
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    r0 = rd_cnt;
    w0 = wr_cnt;
    bus.MemRead_in  = rd;
    bus.MemWrite_in = wr;
    bus.funct3      = f3;
    bus.Addr        = a;
    bus.StoreData   = d;
    bus.req_valid   = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.Load_Result;
    flt = bus.fault;
    @(negedge clk);
    nrd = rd_cnt - r0;
    nwr = wr_cnt - w0;
  endtask

  int          lat, nrd, nwr, t1, t2, guard;
  logic [63:0] res, res1, res2, snap;
  logic        flt;

  initial begin
    tests = 0; fails = 0; cyc = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    bus.req_valid = 1'b0; bus.MemRead_in = 1'b0; bus.MemWrite_in = 1'b0;
    bus.funct3 = 3'b000; bus.Addr = '0; bus.StoreData = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst_memrw", {62'd0, bus.MemRead, bus.MemWrite}, 64'd0);
    chk("rst_fault", {63'd0, bus.fault}, 64'd0);
    chk("rst_load_result", bus.Load_Result, 64'd0);
    chk("rst_mem_addr", bus.Mem_Addr, 64'd0);
    chk("rst_write_data", bus.WriteData, 64'd0);
    @(negedge clk) reset = 1'b0;
    chk("rst_ready", {63'd0, bus.req_ready}, 64'd1);

    // sd preloads
    req(0, 1, 3'b011, 64'h08, 64'h8877665544332211, lat, res, flt, nrd, nwr);
    chk("sd08_lat", 64'(lat), 64'd2);
    chk("sd08_rw", {32'(nrd), 32'(nwr)}, {32'd0, 32'd1});
    chk("sd08_mem", mem[1], 64'h8877665544332211);
    req(0, 1, 3'b011, 64'h00, 64'h1111111111111111, lat, res, flt, nrd, nwr);
    chk("sd00_mem", mem[0], 64'h1111111111111111);

    req(1, 0, 3'b000, 64'h0F, 64'h0, lat, res, flt, nrd, nwr);
    chk("lb0F_lat", 64'(lat), 64'd2);
    chk("lb0F_res", res, 64'hFFFF_FFFF_FFFF_FF88);
    chk("lb0F_fault", {63'd0, flt}, 64'd0);
    req(1, 0, 3'b100, 64'h0F, 64'h0, lat, res, flt, nrd, nwr);
    chk("lbu0F_res", res, 64'h88);
    req(1, 0, 3'b001, 64'h0A, 64'h0, lat, res, flt, nrd, nwr);
    chk("lh0A_res", res, 64'h4433);
    req(1, 0, 3'b010, 64'h0C, 64'h0, lat, res, flt, nrd, nwr);
    chk("lw0C_res", res, 64'hFFFF_FFFF_8877_6655);
    req(1, 0, 3'b110, 64'h0C, 64'h0, lat, res, flt, nrd, nwr);
    chk("lwu0C_res", res, 64'h0000_0000_8877_6655);
    req(1, 0, 3'b101, 64'h0E, 64'h0, lat, res, flt, nrd, nwr);
    chk("lhu0E_res", res, 64'h8877);

    req(0, 1, 3'b011, 64'h10, 64'h0123456789ABCDEF, lat, res, flt, nrd, nwr);
    chk("sd10_lat", 64'(lat), 64'd2);
    chk("sd10_rw", {32'(nrd), 32'(nwr)}, {32'd0, 32'd1});
    req(1, 0, 3'b011, 64'h10, 64'h0, lat, res, flt, nrd, nwr);
    chk("ld10_res", res, 64'h0123456789ABCDEF);

    // sub-doubleword stores go through read-modify-write
    req(0, 1, 3'b001, 64'h02, 64'hFFFF_FFFF_FFFF_BEEF, lat, res, flt, nrd, nwr);
    chk("sh02_lat", 64'(lat), 64'd3);
    chk("sh02_rw", {32'(nrd), 32'(nwr)}, {32'd1, 32'd1});
    chk("sh02_keep_result", res, 64'h0123456789ABCDEF);
    req(1, 0, 3'b011, 64'h00, 64'h0, lat, res, flt, nrd, nwr);
    chk("ld00_res", res, 64'h11111111BEEF1111);
    req(0, 1, 3'b000, 64'h13, 64'h0000_0000_0000_12AA, lat, res, flt, nrd, nwr);
    chk("sb13_lat", 64'(lat), 64'd3);
    chk("sb13_mem", mem[2], 64'h01234567AAABCDEF);
    req(0, 1, 3'b010, 64'h14, 64'h5555_5555_DEAD_BEEF, lat, res, flt, nrd, nwr);
    req(1, 0, 3'b011, 64'h10, 64'h0, lat, res, flt, nrd, nwr);
    chk("ld10_after_sw", res, 64'hDEADBEEF_AAABCDEF);

    // faults
    req(1, 0, 3'b010, 64'h06, 64'h0, lat, res, flt, nrd, nwr);
    chk("lw06_fault", {63'd0, flt}, 64'd1);
    chk("lw06_lat", 64'(lat), 64'd1);
    chk("lw06_rw", {32'(nrd), 32'(nwr)}, 64'd0);
    chk("lw06_result_zero", res, 64'd0);
    req(1, 0, 3'b011, 64'h40, 64'h0, lat, res, flt, nrd, nwr);
    chk("ld40_fault", {63'd0, flt}, 64'd1);
    req(1, 0, 3'b011, 64'h38, 64'h0, lat, res, flt, nrd, nwr);
    chk("ld38_ok", {63'd0, flt}, 64'd0);
    req(0, 1, 3'b100, 64'h08, 64'h0, lat, res, flt, nrd, nwr);
    chk("st_f3_100_fault", {31'd0, flt, 32'(nwr)}, {31'd0, 1'b1, 32'd0});
    req(1, 1, 3'b011, 64'h08, 64'h0, lat, res, flt, nrd, nwr);
    chk("both_ops_fault", {63'd0, flt}, 64'd1);
    req(0, 0, 3'b011, 64'h08, 64'h0, lat, res, flt, nrd, nwr);
    chk("no_op_fault", {63'd0, flt}, 64'd1);
    req(1, 0, 3'b111, 64'h08, 64'h0, lat, res, flt, nrd, nwr);
    chk("f3_111_fault", {63'd0, flt}, 64'd1);
    req(0, 1, 3'b001, 64'h03, 64'h0, lat, res, flt, nrd, nwr);
    chk("sh03_fault", {31'd0, flt, 32'(nrd + nwr)}, {31'd0, 1'b1, 32'd0});

    // reset while the RMW read is in progress
    req(0, 1, 3'b011, 64'h18, 64'h0F0F0F0F0F0F0F0F, lat, res, flt, nrd, nwr);
    snap = mem[3];
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    bus.MemRead_in = 1'b0; bus.MemWrite_in = 1'b1; bus.funct3 = 3'b010;
    bus.Addr = 64'h18; bus.StoreData = 64'h0000_0000_5555_5555; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("rmw_in_rd", {63'd0, bus.MemRead}, 64'd1);
    t1 = wr_cnt;
    #1 reset = 1'b1;
    #1;
    chk("rmw_rst_outputs", {60'd0, bus.MemRead, bus.MemWrite, bus.resp_valid, bus.fault}, 64'd0);
    chk("rmw_rst_addr_data", bus.Mem_Addr | bus.WriteData | bus.Load_Result, 64'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmw_rst_mem", mem[3], snap);
    chk("rmw_rst_nowrite", 64'(wr_cnt - t1), 64'd0);

    // back-to-back loads with req_valid held high
    @(negedge clk);
    bus.MemRead_in = 1'b1; bus.MemWrite_in = 1'b0; bus.funct3 = 3'b011;
    bus.Addr = 64'h08; bus.req_valid = 1'b1;
    t1 = -1; t2 = -1; guard = 0; res1 = '0; res2 = '0;
    while (t2 < 0 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
      if (bus.resp_valid) begin
        if (t1 < 0) begin
          t1 = cyc; res1 = bus.Load_Result;
          bus.Addr = 64'h10;
        end else begin
          t2 = cyc; res2 = bus.Load_Result;
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.req_valid = 1'b0;
    chk("b2b_first_lat", 64'(guard - (t2 - t1)), 64'd2);
    chk("b2b_spacing", 64'(t2 - t1), 64'd3);
    chk("b2b_res1", res1, 64'h8877665544332211);
    chk("b2b_res2", res2, 64'hDEADBEEF_AAABCDEF);
    repeat (3) @(negedge clk);
    chk("b2b_no_third", {63'd0, bus.resp_valid}, 64'd0);
    chk("never_both_rw", 64'(both_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
